// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU blocks, including the divide accelerator.
package cpu_pkg;

  localparam int DIV_WIDTH          = 16;
  localparam int DIV_BITS_PER_CYCLE = 1;

  // Kept distinct from the accelerator machine's t_state names.
  typedef enum logic [1:0] {
    S_DIV_IDLE,
    S_DIV_BUSY,
    S_DIV_DONE
  } t_div_state;

  function automatic int div_cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             d_msb,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The extra top bit keeps the partial remainder exact even when the divisor's msb is set.
  always_comb begin
    shifted = {r_in, d_msb};
    diff    = shifted - {1'b0, v};
    q_bit   = (shifted >= {1'b0, v});
    r_out   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_acc.sv
// Iterative unsigned restoring divider with a one-cycle Done pulse and held results.
module div_acc
  import cpu_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             Busy
);

  localparam int                N     = WIDTH / BITS_PER_CYCLE;
  localparam int                CNT_W = div_cnt_width(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2) || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("div_acc: BITS_PER_CYCLE must be 1 or 2 and divide WIDTH");
  end

  t_div_state       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] r_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] d_chain [BITS_PER_CYCLE+1];

  assign r_chain[0] = r_q;
  assign d_chain[0] = d_q;

  // Quotient bits refill the dividend register from the bottom as its msbs are consumed.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
      .r_in  (r_chain[gi]),
      .d_msb (d_chain[gi][WIDTH-1]),
      .v     (v_q),
      .r_out (r_chain[gi+1]),
      .q_bit (q_bit)
    );

    assign d_chain[gi+1] = {d_chain[gi][WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_DIV_IDLE: begin
        if (StartDiv) begin
          d_d   = Divident;
          v_d   = Divisor;
          r_d   = '0;
          cnt_d = '0;
          if (Divisor == '0) begin
            state_d = S_DIV_DONE;
            quot_d  = '1;
            rem_d   = Divident;
          end else begin
            state_d = S_DIV_BUSY;
          end
        end
      end
      S_DIV_BUSY: begin
        r_d   = r_chain[BITS_PER_CYCLE];
        d_d   = d_chain[BITS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DIV_DONE;
          quot_d  = d_chain[BITS_PER_CYCLE];
          rem_d   = r_chain[BITS_PER_CYCLE];
        end
      end
      S_DIV_DONE: state_d = S_DIV_IDLE;
      default:    state_d = S_DIV_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_DIV_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Done      = (state_q == S_DIV_DONE);
  assign Busy      = (state_q == S_DIV_BUSY);

endmodule

// File: tb/tb_div_acc.sv
// Scoreboard bench for div_acc: one- and two-bit-per-cycle builds driven with the same operands.
module tb_div_acc;

  localparam int W  = 16;
  localparam int N1 = 16;
  localparam int N2 = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int unsigned  cyc;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         StartDiv = 1'b0;
  logic [W-1:0] Divident = '0;
  logic [W-1:0] Divisor = '0;
  logic [W-1:0] q_o [2];
  logic [W-1:0] r_o [2];
  logic         done_o [2];
  logic         busy_o [2];

  exp_t         sb [2][$];
  int unsigned  cyc = 0;
  int unsigned  blo [2] = '{1, 1};
  int unsigned  bhi [2] = '{0, 0};
  logic [W-1:0] hq [2] = '{'0, '0};
  logic [W-1:0] hr [2] = '{'0, '0};
  int           nst [2] = '{N1, N2};
  int           vectors = 0;
  int           miscompares = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  div_acc #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .StartDiv(StartDiv), .Divident(Divident), .Divisor(Divisor),
    .Quotient(q_o[0]), .Remainder(r_o[0]), .Done(done_o[0]), .Busy(busy_o[0])
  );

  div_acc #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .StartDiv(StartDiv), .Divident(Divident), .Divisor(Divisor),
    .Quotient(q_o[1]), .Remainder(r_o[1]), .Done(done_o[1]), .Busy(busy_o[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, k + 1, cyc, act, expv);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all ones and the dividend.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned t, input int k);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.cyc = t + 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.cyc = t + nst[k] + 1;
    end
    return e;
  endfunction

  // Monitor: busy window, done timing/results, and held outputs every cycle.
  always @(negedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 32'(busy_o[k]), 32'(cyc >= blo[k] && cyc <= bhi[k]));
        if (done_o[k]) begin
          if (sb[k].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_unexpected dut%0d cycle %0d: got Done=1, expected Done=0", k + 1, cyc);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            chk("done_cycle", k, cyc, e.cyc);
            hq[k] = e.q;
            hr[k] = e.r;
          end
        end else if (sb[k].size() > 0 && cyc > sb[k][0].cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL done_missing dut%0d cycle %0d: got no Done, expected Done at %0d",
                   k + 1, cyc, sb[k][0].cyc);
          void'(sb[k].pop_front());
        end
        chk("quotient", k, 32'(q_o[k]), 32'(hq[k]));
        chk("remainder", k, 32'(r_o[k]), 32'(hr[k]));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    @(negedge Clk);
    Divident = a;
    Divisor  = b;
    StartDiv = 1'b1;
    if (accept) begin
      for (int k = 0; k < 2; k++) begin
        sb[k].push_back(model(a, b, cyc, k));
        if (b != 0) begin
          blo[k] = cyc + 1;
          bhi[k] = cyc + nst[k];
        end else begin
          blo[k] = 1;
          bhi[k] = 0;
        end
      end
    end
    @(negedge Clk);
    StartDiv = 1'b0;
    Divident = W'($urandom);
    Divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done_o[0]) return;
      @(negedge Clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done cycle %0d: got no Done within 100 cycles, expected Done", cyc);
  endtask

  task automatic check_cleared(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_busy"}, k, 32'(busy_o[k]), 32'(0));
      chk({name, "_done"}, k, 32'(done_o[k]), 32'(0));
      chk({name, "_quot"}, k, 32'(q_o[k]), 32'(0));
      chk({name, "_rem"}, k, 32'(r_o[k]), 32'(0));
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int sel;

    #3;
    check_cleared("reset");
    @(negedge Clk);
    #1 Reset = 1'b0;

    start_op(16'd20000, 16'd10, 1'b1);
    wait_done();
    repeat (3) @(negedge Clk);

    start_op(16'd100, 16'd7, 1'b1);
    wait_done();
    start_op(16'hFFFF, 16'd1, 1'b1);
    wait_done();

    start_op(16'd7, 16'd0, 1'b1);
    wait_done();
    repeat (2) @(negedge Clk);

    start_op(16'd5, 16'd9, 1'b1);
    @(negedge Clk);
    start_op(16'd50, 16'd5, 1'b0);
    wait_done();

    // Abort mid-operation with an asynchronous reset away from any clock edge.
    start_op(16'd20000, 16'd10, 1'b1);
    repeat (7) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_cleared("async_reset");
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      hq[k]  = '0;
      hr[k]  = '0;
      blo[k] = 1;
      bhi[k] = 0;
    end
    @(negedge Clk);
    #1 Reset = 1'b0;
    repeat (20) @(negedge Clk);
    start_op(16'd9, 16'd3, 1'b1);
    wait_done();

    for (int n = 0; n < 1000; n++) begin
      sel = int'($urandom_range(0, 9));
      a   = W'($urandom);
      b   = W'($urandom);
      case (sel)
        0: b = '0;
        1: b = 16'd1;
        2: begin
          b = W'($urandom_range(1, 65535));
          a = W'($urandom) % b;
        end
        3: a = '0;
        4: b = W'($urandom_range(1, 15));
        default: ;
      endcase
      start_op(a, b, 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (20) @(negedge Clk);
    for (int k = 0; k < 2; k++) chk("sb_drained", k, 32'(sb[k].size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
